// File: rtl/ksa_if.sv
// Start/ready handshake plus single-port S memory bus for the ARC4 key scheduler.
// The master drives start, key and memory read data; the slave (ksa) drives the rest.
interface ksa_if;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic [7:0]  addr;
  logic [7:0]  rddata;
  logic [7:0]  wrdata;
  logic        wren;

  modport master (
    output en, key, rddata,
    input  rdy, addr, wrdata, wren
  );

  modport slave (
    input  en, key, rddata,
    output rdy, addr, wrdata, wren
  );
endinterface

// File: rtl/ksa.sv
// ARC4 key scheduling performed in place on an external 256x8 S memory with 1-cycle read latency.
// Four cycles per iteration, 1024 busy cycles per run; en is ignored while busy (no queuing).
module ksa (
  input  logic clk,
  input  logic rst_n,
  ksa_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RD_I, RD_J, WR_I, WR_J} state_t;

  state_t      state, state_nxt;
  logic [7:0]  i, j, si;
  logic [1:0]  kidx;
  logic [23:0] key_q;
  logic [7:0]  kbyte;
  logic [7:0]  jn;

  // kidx tracks i mod 3 incrementally so no divider is needed.
  always_comb begin
    case (kidx)
      2'd0:    kbyte = key_q[23:16];
      2'd1:    kbyte = key_q[15:8];
      default: kbyte = key_q[7:0];
    endcase
  end

  assign jn = j + bus.rddata + kbyte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      i     <= 8'd0;
      j     <= 8'd0;
      si    <= 8'd0;
      kidx  <= 2'd0;
      key_q <= 24'd0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (bus.en) begin
            key_q <= bus.key;
            i     <= 8'd0;
            j     <= 8'd0;
            kidx  <= 2'd0;
          end
        end
        RD_J: begin
          si <= bus.rddata;
          j  <= jn;
        end
        WR_J: begin
          i    <= i + 8'd1;
          kidx <= (kidx == 2'd2) ? 2'd0 : kidx + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode from state only, so an async reset drops wren and rdy rises at once.
  always_comb begin
    state_nxt  = state;
    bus.rdy    = 1'b0;
    bus.addr   = 8'd0;
    bus.wrdata = 8'd0;
    bus.wren   = 1'b0;
    case (state)
      IDLE: begin
        bus.rdy = 1'b1;
        if (bus.en) state_nxt = RD_I;
      end
      RD_I: begin
        bus.addr  = i;
        state_nxt = RD_J;
      end
      RD_J: begin
        bus.addr  = jn;
        state_nxt = WR_I;
      end
      WR_I: begin
        bus.addr   = i;
        bus.wrdata = bus.rddata;
        bus.wren   = 1'b1;
        state_nxt  = WR_J;
      end
      WR_J: begin
        bus.addr   = j;
        bus.wrdata = si;
        bus.wren   = 1'b1;
        state_nxt  = (i == 8'd255) ? IDLE : RD_I;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ksa.sv
// Bench for ksa: behavioural S memory, software KSA model feeding a write/final-state scoreboard.
module tb_ksa;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ksa_if bus ();

  ksa dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  logic [7:0] mem [256];
  logic       init_req;
  wr_t        wq[$];
  logic [7:0] fq[$];
  int         vectors;
  int         miscompares;

  // Synchronous-read S memory; init_req reloads the identity permutation.
  always @(posedge clk) begin
    if (init_req) begin
      for (int k = 0; k < 256; k++) mem[k] <= k[7:0];
    end else if (bus.wren) begin
      mem[bus.addr] <= bus.wrdata;
    end
    bus.rddata <= mem[bus.addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic init_identity();
    init_req = 1'b1;
    @(posedge clk);
    #1 init_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic build_expected(input logic [23:0] k);
    logic [7:0] m [256];
    logic [7:0] jj, t, kb;
    wq.delete();
    fq.delete();
    jj = 8'd0;
    for (int n = 0; n < 256; n++) m[n] = mem[n];
    for (int n = 0; n < 256; n++) begin
      kb = (n % 3 == 0) ? k[23:16] : (n % 3 == 1) ? k[15:8] : k[7:0];
      jj = jj + m[n] + kb;
      wq.push_back('{n[7:0], m[jj]});
      wq.push_back('{jj, m[n]});
      t     = m[n];
      m[n]  = m[jj];
      m[jj] = t;
    end
    for (int n = 0; n < 256; n++) fq.push_back(m[n]);
  endtask

  // Starts a run from a negedge and returns on the negedge where rdy is seen high again.
  task automatic run(input string tag, input logic [23:0] k, input bit hold_en,
                     input bit toggle_key, input bit pulse_test, input int rst_at);
    int  busy;
    int  writes;
    wr_t w;
    build_expected(k);
    bus.key = k;
    bus.en  = 1'b1;
    @(posedge clk);
    #1 if (!hold_en) bus.en = 1'b0;
    @(negedge clk);
    chk({tag, " rdy after accept"}, 32'(bus.rdy), 32'd0);
    busy   = 0;
    writes = 0;
    while (bus.rdy == 1'b0 && busy < 2000) begin
      busy++;
      if (bus.wren) begin
        writes++;
        if (wq.size() == 0) begin
          chk({tag, " write count"}, writes, 512);
        end else begin
          w = wq.pop_front();
          chk({tag, " write addr"}, 32'(bus.addr), 32'(w.a));
          chk({tag, " write data"}, 32'(bus.wrdata), 32'(w.d));
        end
      end
      if (toggle_key) bus.key = 24'($urandom);
      if (pulse_test) bus.en = (busy == 10 || busy == 300);
      if (busy == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk({tag, " rdy in reset"}, 32'(bus.rdy), 32'd1);
        chk({tag, " wren in reset"}, 32'(bus.wren), 32'd0);
        chk({tag, " addr in reset"}, 32'(bus.addr), 32'd0);
        chk({tag, " wrdata in reset"}, 32'(bus.wrdata), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wq.delete();
        fq.delete();
        init_identity();
        return;
      end
      @(negedge clk);
    end
    if (pulse_test) bus.en = 1'b0;
    chk({tag, " busy cycles"}, busy, 1024);
    chk({tag, " writes"}, writes, 512);
    chk({tag, " writes left"}, wq.size(), 0);
    for (int n = 0; n < 256; n++) chk({tag, " final S"}, 32'(mem[n]), 32'(fq.pop_front()));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    init_req    = 1'b0;
    rst_n       = 1'b0;
    bus.en      = 1'b0;
    bus.key     = 24'd0;
    init_identity();
    repeat (2) @(negedge clk);
    chk("reset rdy", 32'(bus.rdy), 32'd1);
    chk("reset wren", 32'(bus.wren), 32'd0);
    chk("reset addr", 32'(bus.addr), 32'd0);
    chk("reset wrdata", 32'(bus.wrdata), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run("zero key", 24'h000000, 1'b0, 1'b0, 1'b0, -1);

    init_identity();
    run("key 1E4600", 24'h1E4600, 1'b0, 1'b0, 1'b0, -1);

    init_identity();
    run("en pulses", 24'h123456, 1'b0, 1'b0, 1'b1, -1);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("no queued run", 32'(bus.rdy), 32'd1);
    end

    init_identity();
    run("reset mid-run", 24'hA5A5A5, 1'b0, 1'b0, 1'b0, 500);
    run("after reset", 24'hA5A5A5, 1'b0, 1'b0, 1'b0, -1);

    init_identity();
    run("held en 1", 24'h010203, 1'b1, 1'b0, 1'b0, -1);
    run("held en 2", 24'hFEDCBA, 1'b1, 1'b0, 1'b0, -1);
    bus.en = 1'b0;
    @(negedge clk);
    chk("idle after held en", 32'(bus.rdy), 32'd1);

    init_identity();
    run("key toggling", 24'h1E4600, 1'b0, 1'b1, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
